// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the memory port arbiter, its two requesters
// (fetch and MEM stage), the unified memory and pipeline control.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic [DW-1:0]   if_rdata;
    logic            if_ready;
    logic            d_re;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic [DW-1:0]   d_rdata;
    logic            d_ready;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   mem_rdata;
    logic            mem_valid;
    logic            stall_fetch;
    logic            stall_mem;
    logic            access_err;

    modport master (
        input  if_req, if_addr, d_re, d_we, d_addr, d_wdata, d_be,
        input  mem_rdata, mem_valid,
        output if_rdata, if_ready, d_rdata, d_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output stall_fetch, stall_mem, access_err
    );

    modport slave (
        output if_req, if_addr, d_re, d_we, d_addr, d_wdata, d_be,
        output mem_rdata, mem_valid,
        input  if_rdata, if_ready, d_rdata, d_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  stall_fetch, stall_mem, access_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch
// and the MEM stage, with a per-access watchdog and pipeline stall outputs.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input logic                clk,
    input logic                reset_n,
    mem_port_arbiter_if.master bus
);
    localparam int BW = DW / 8;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DATA, INSTR, RESP} state_e;

    state_e          state_q, state_d;
    logic            last_data_q, last_data_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BW-1:0]   mem_be_q, mem_be_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            if_ready_q, if_ready_d;
    logic            d_ready_q, d_ready_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            d_pend;
    logic            f_pend;
    logic            pick_data;
    logic            done;
    logic [DW-1:0]   rdata;

    assign d_pend    = bus.d_re | bus.d_we;
    assign f_pend    = bus.if_req;
    // Data wins unless fetch is also waiting and data was served last.
    assign pick_data = d_pend & (~f_pend | ~last_data_q);
    assign done      = bus.mem_valid | (cnt_q == CW'(TIMEOUT - 1));
    assign rdata     = bus.mem_valid ? bus.mem_rdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_data_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        err_d       = err_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_data) begin
                    state_d     = DATA;
                    last_data_d = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_be_d    = bus.d_be;
                    cnt_d       = '0;
                    if (bus.d_re && bus.d_we) err_d = 1'b1;
                end else if (f_pend) begin
                    state_d     = INSTR;
                    last_data_d = 1'b0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = '1;
                    cnt_d       = '0;
                end
            end
            DATA, INSTR: begin
                cnt_d = cnt_q + CW'(1);
                if (done) begin
                    state_d  = RESP;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (!bus.mem_valid) err_d = 1'b1;
                    if (state_q == INSTR) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = rdata;
                    end else begin
                        d_ready_d = 1'b1;
                        if (!mem_we_q) d_rdata_d = rdata;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_be      = mem_be_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.if_ready    = if_ready_q;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.d_ready     = d_ready_q;
    assign bus.access_err  = err_q;
    assign bus.stall_fetch = reset_n & bus.if_req & ~if_ready_q;
    assign bus.stall_mem   = reset_n & d_pend & ~d_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized rounds checked against a
// transaction-level model of the memory port arbiter.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs;
        bus.if_req = 0; bus.if_addr = '0;
        bus.d_re = 0; bus.d_we = 0; bus.d_addr = '0;
        bus.d_wdata = '0; bus.d_be = '0;
        bus.mem_rdata = '0; bus.mem_valid = 0;
    endtask

    logic [31:0] tbmem [8];
    logic [31:0] shadow [8];
    bit          ord [2];
    logic [31:0] exv [2];
    bit          last_d;
    logic [31:0] dr_model;
    int          wcnt, wtgt, served, nexp, cyc, idx;
    bit          pf, pd, st;
    int          fi, di;
    logic [31:0] wd;
    logic [3:0]  be;

    initial begin
        idle_inputs();
        // reset state, stalls forced low while in reset
        bus.if_req = 1; bus.d_re = 1;
        #12;
        chk("rst_stall_fetch", bus.stall_fetch, 0);
        chk("rst_stall_mem", bus.stall_mem, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_ready", {bus.if_ready, bus.d_ready}, 0);
        chk("rst_err", bus.access_err, 0);
        chk("rst_bus", {bus.mem_addr, bus.mem_wdata}, 0);
        chk("rst_be", bus.mem_be, 0);
        chk("rst_rdata", {bus.if_rdata, bus.d_rdata}, 0);
        idle_inputs();
        @(posedge clk); #2 reset_n = 1;
        tick();

        // single load, zero-wait
        bus.d_re = 1; bus.d_addr = 32'h100; #1;
        chk("ld_c0_stall", bus.stall_mem, 1);
        chk("ld_c0_en", bus.mem_en, 0);
        tick();
        chk("ld_c1_en", bus.mem_en, 1);
        chk("ld_c1_addr", bus.mem_addr, 32'h100);
        chk("ld_c1_we", bus.mem_we, 0);
        chk("ld_c1_stall", bus.stall_mem, 1);
        bus.mem_valid = 1; bus.mem_rdata = 32'hDEADBEEF;
        tick();
        bus.mem_valid = 0;
        chk("ld_c2_en", bus.mem_en, 0);
        chk("ld_c2_rdy", bus.d_ready, 1);
        chk("ld_c2_data", bus.d_rdata, 32'hDEADBEEF);
        chk("ld_c2_stall", bus.stall_mem, 0);
        bus.d_re = 0;
        tick();
        chk("ld_c3_rdy", bus.d_ready, 0);
        chk("ld_c3_en", bus.mem_en, 0);

        // store with 3 wait states
        bus.d_we = 1; bus.d_addr = 32'h20;
        bus.d_wdata = 32'h12345678; bus.d_be = 4'b0011;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("st_en", bus.mem_en, 1);
            chk("st_we", bus.mem_we, 1);
            chk("st_addr", bus.mem_addr, 32'h20);
            chk("st_wdata", bus.mem_wdata, 32'h12345678);
            chk("st_be", bus.mem_be, 4'b0011);
            chk("st_rdy_early", bus.d_ready, 0);
            if (c == 4) bus.mem_valid = 1;
        end
        tick();
        bus.mem_valid = 0;
        chk("st_rdy", bus.d_ready, 1);
        chk("st_en_off", bus.mem_en, 0);
        chk("st_rdata_keep", bus.d_rdata, 32'hDEADBEEF);
        bus.d_we = 0;
        tick();
        chk("st_rdy_once", bus.d_ready, 0);

        // simultaneous requests from reset, 1-wait memory
        reset_n = 0;
        bus.if_req = 1; bus.if_addr = 32'h200;
        bus.d_re = 1; bus.d_addr = 32'h300; bus.d_be = 4'hF;
        #3;
        @(posedge clk); #2 reset_n = 1; #1;
        chk("rr_c0_sf", bus.stall_fetch, 1);
        chk("rr_c0_sm", bus.stall_mem, 1);
        for (int k = 0; k < 4; k++) begin
            bit ed;
            ed = (k % 2 == 0);
            tick();
            chk("rr_en", bus.mem_en, 1);
            chk("rr_addr", bus.mem_addr, ed ? 32'h300 : 32'h200);
            chk("rr_sf", bus.stall_fetch, 1);
            tick();
            chk("rr_en2", bus.mem_en, 1);
            bus.mem_valid = 1; bus.mem_rdata = 32'hA000 + k;
            tick();
            bus.mem_valid = 0;
            chk("rr_if_rdy", bus.if_ready, !ed);
            chk("rr_d_rdy", bus.d_ready, ed);
            if (ed) chk("rr_ddata", bus.d_rdata, 32'hA000 + k);
            else chk("rr_idata", bus.if_rdata, 32'hA000 + k);
            chk("rr_sf_resp", bus.stall_fetch, ed);
            if (k == 3) begin bus.if_req = 0; bus.d_re = 0; end
            tick();
            chk("rr_gap", {bus.mem_en, bus.if_ready, bus.d_ready}, 0);
        end

        // fetch timeout
        chk("to_err0", bus.access_err, 0);
        bus.if_req = 1; bus.if_addr = 32'h400; #1;
        chk("to_sf", bus.stall_fetch, 1);
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk("to_en", bus.mem_en, 1);
        end
        tick();
        chk("to_en_off", bus.mem_en, 0);
        chk("to_rdy", bus.if_ready, 1);
        chk("to_data", bus.if_rdata, 0);
        chk("to_err", bus.access_err, 1);
        bus.if_req = 0;
        tick(); tick();
        chk("to_err_sticky", bus.access_err, 1);
        chk("to_rdy_once", bus.if_ready, 0);

        // reset during the 2nd wait cycle of a load
        bus.d_re = 1; bus.d_addr = 32'h180;
        tick(); tick();
        chk("mr_en", bus.mem_en, 1);
        #1 reset_n = 0; #1;
        chk("mr_en_off", bus.mem_en, 0);
        chk("mr_rdy", bus.d_ready, 0);
        chk("mr_sm", bus.stall_mem, 0);
        chk("mr_err", bus.access_err, 0);
        @(posedge clk); #2 reset_n = 1; #1;
        chk("mr_c0_en", bus.mem_en, 0);
        chk("mr_c0_sm", bus.stall_mem, 1);
        tick();
        chk("mr_c1_en", bus.mem_en, 1);
        chk("mr_c1_addr", bus.mem_addr, 32'h180);
        bus.mem_valid = 1; bus.mem_rdata = 32'h55AA55AA;
        tick();
        bus.mem_valid = 0;
        chk("mr_rdy", bus.d_ready, 1);
        chk("mr_data", bus.d_rdata, 32'h55AA55AA);
        bus.d_re = 0;
        tick();

        // d_re and d_we together
        bus.d_re = 1; bus.d_we = 1; bus.d_addr = 32'h40;
        bus.d_wdata = 32'hCAFEF00D; bus.d_be = 4'hF;
        tick();
        chk("pe_en", bus.mem_en, 1);
        chk("pe_we", bus.mem_we, 1);
        chk("pe_wdata", bus.mem_wdata, 32'hCAFEF00D);
        chk("pe_err", bus.access_err, 1);
        bus.mem_valid = 1;
        tick();
        bus.mem_valid = 0;
        chk("pe_rdy", bus.d_ready, 1);
        chk("pe_keep", bus.d_rdata, 32'h55AA55AA);
        bus.d_re = 0; bus.d_we = 0;
        tick();
        chk("pe_rdy_once", bus.d_ready, 0);
        chk("pe_err_sticky", bus.access_err, 1);

        // randomized rounds against a transaction model
        idle_inputs();
        reset_n = 0;
        for (int i = 0; i < 8; i++) begin
            tbmem[i] = $urandom;
            shadow[i] = tbmem[i];
        end
        last_d = 0;
        dr_model = '0;
        @(posedge clk); #2 reset_n = 1;
        wcnt = 0; wtgt = $urandom_range(0, 3);
        for (int r = 0; r < 60; r++) begin
            pf = 1'($urandom_range(0, 1));
            pd = 1'($urandom_range(0, 1));
            if (!pf && !pd) pf = 1;
            st = 1'($urandom_range(0, 1));
            fi = $urandom_range(0, 7);
            di = $urandom_range(0, 7);
            wd = $urandom;
            be = 4'($urandom_range(1, 15));
            if (pf && pd) begin
                nexp = 2;
                ord[0] = !last_d;
                ord[1] = last_d;
            end else begin
                nexp = 1;
                ord[0] = pd;
            end
            last_d = ord[nexp-1];
            for (int j = 0; j < nexp; j++) begin
                if (!ord[j]) exv[j] = shadow[fi];
                else if (!st) begin
                    exv[j] = shadow[di];
                    dr_model = exv[j];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) shadow[di][8*b +: 8] = wd[8*b +: 8];
                    exv[j] = dr_model;
                end
            end
            bus.if_req = pf; bus.if_addr = 32'h1000 + 32'(fi * 4);
            bus.d_re = pd & !st; bus.d_we = pd & st;
            bus.d_addr = 32'h1000 + 32'(di * 4);
            bus.d_wdata = wd; bus.d_be = be;
            served = 0; cyc = 0;
            while (served < nexp && cyc < 200) begin
                tick();
                cyc++;
                if (bus.mem_en) begin
                    if (wcnt == wtgt) begin
                        bus.mem_valid = 1;
                        idx = int'(bus.mem_addr[4:2]);
                        if (bus.mem_we) begin
                            for (int b = 0; b < 4; b++)
                                if (bus.mem_be[b])
                                    tbmem[idx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
                        end else bus.mem_rdata = tbmem[idx];
                    end else begin
                        bus.mem_valid = 0;
                        wcnt++;
                    end
                end else begin
                    bus.mem_valid = 0;
                    wcnt = 0;
                    wtgt = $urandom_range(0, 3);
                end
                if (bus.if_ready || bus.d_ready) begin
                    chk("rnd_side", bus.d_ready, ord[served]);
                    chk("rnd_one_rdy", bus.if_ready & bus.d_ready, 0);
                    if (ord[served]) begin
                        chk("rnd_ddata", bus.d_rdata, exv[served]);
                        bus.d_re = 0; bus.d_we = 0;
                    end else begin
                        chk("rnd_idata", bus.if_rdata, exv[served]);
                        bus.if_req = 0;
                    end
                    served++;
                end
            end
            if (served < nexp) chk("rnd_timeout", served, nexp);
            tick();
            bus.mem_valid = 0;
        end
        chk("rnd_no_err", bus.access_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
